master_fifo: RTL and testbench

MASTER_FIFO -- requirements
Module: master_fifo

---
 rtl/master_fifo.sv | 73 +++++++
 tb/tb_master_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/master_fifo.sv
// rtl/master_fifo.sv - DEPTH-entry circular buffer between a source and a downstream receiver
// Flow control flags come only from the occupancy register, so ready never reaches push_ready.

module master_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_en,
   input  logic [WIDTH-1:0]         mdata_in,
   output logic                     push_ready,
   output logic                     valid,
   input  logic                     ready,
   output logic [WIDTH-1:0]         mdata_out,
   output logic [$clog2(DEPTH):0]   count,
   output logic [7:0]               drop_cnt
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic [7:0]       r_drop;

   logic w_push;
   logic w_pop;
   logic w_drop;

   // DEPTH is a power of two, so the occupancy MSB alone marks full.
   assign push_ready = ~r_count[AW];
   assign valid      = |r_count;
   assign mdata_out  = r_mem[r_rptr];
   assign count      = r_count;
   assign drop_cnt   = r_drop;

   assign w_push = valid_en & push_ready;
   assign w_pop  = valid & ready;
   assign w_drop = valid_en & ~push_ready & (r_drop != 8'hFF);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= mdata_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_drop  <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_drop <= r_drop + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_master_fifo.sv
// tb/tb_master_fifo.sv - directed and random checks of master_fifo against a queue model
// The model keeps buffered words in a queue and a saturating drop tally.

module tb_master_fifo;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic             clk;
   logic             rst;
   logic             valid_en;
   logic [WIDTH-1:0] mdata_in;
   logic             push_ready;
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] mdata_out;
   logic [2:0]       count;
   logic [7:0]       drop_cnt;

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] q[$];
   int               m_drop = 0;

   master_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_en   (valid_en),
      .mdata_in   (mdata_in),
      .push_ready (push_ready),
      .valid      (valid),
      .ready      (ready),
      .mdata_out  (mdata_out),
      .count      (count),
      .drop_cnt   (drop_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".count"}, 32'(count), 32'(q.size()));
      chk({tag, ".valid"}, 32'(valid), 32'(q.size() != 0));
      chk({tag, ".push_ready"}, 32'(push_ready), 32'(q.size() < DEPTH));
      chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
      if (q.size() != 0) begin
         chk({tag, ".mdata_out"}, 32'(mdata_out), 32'(q[0]));
      end
   endtask

   // One clock: drive inputs, advance the model by the same decisions the spec prescribes, check.
   task automatic step(input string tag, input logic ve, input logic [WIDTH-1:0] d, input logic rd);
      bit do_push;
      bit do_pop;
      valid_en = ve;
      mdata_in = d;
      ready    = rd;
      do_push  = ve && (q.size() < DEPTH);
      do_pop   = rd && (q.size() > 0);
      if (ve && !do_push && m_drop < 255) m_drop++;
      @(posedge clk);
      #1;
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
      check_state(tag);
   endtask

   initial begin
      rst      = 1'b0;
      valid_en = 1'b0;
      mdata_in = '0;
      ready    = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset.count", 32'(count), 32'd0);
      chk("reset.valid", 32'(valid), 32'd0);
      chk("reset.push_ready", 32'(push_ready), 32'd1);
      chk("reset.drop_cnt", 32'(drop_cnt), 32'd0);
      rst = 1'b1;

      step("single.push", 1'b1, 8'hA5, 1'b1);
      chk("single.data", 32'(mdata_out), 32'h A5);
      chk("single.valid", 32'(valid), 32'd1);
      step("single.pop", 1'b0, 8'h00, 1'b1);
      chk("single.empty", 32'(count), 32'd0);

      step("bp.p0", 1'b1, 8'h11, 1'b0);
      step("bp.p1", 1'b1, 8'h22, 1'b0);
      step("bp.p2", 1'b1, 8'h33, 1'b0);
      step("bp.p3", 1'b1, 8'h44, 1'b0);
      chk("bp.full_count", 32'(count), 32'd4);
      chk("bp.full_ready", 32'(push_ready), 32'd0);
      chk("bp.head_held", 32'(mdata_out), 32'h11);
      for (int i = 0; i < 4; i++) begin
         chk("bp.order", 32'(mdata_out), 32'(8'h11 * (i + 1)));
         step("bp.drain", 1'b0, 8'h00, 1'b1);
      end

      for (int i = 0; i < 4; i++) step("ovf.fill", 1'b1, 8'(8'h60 + i), 1'b0);
      for (int i = 0; i < 3; i++) step("ovf.drop", 1'b1, 8'h55, 1'b0);
      chk("ovf.drop_cnt", 32'(drop_cnt), 32'd3);
      chk("ovf.count", 32'(count), 32'd4);
      step("ovf.full_pop", 1'b1, 8'h55, 1'b1);
      chk("ovf.refused_with_pop", 32'(count), 32'd3);
      for (int i = 0; i < 3; i++) begin
         chk("ovf.no55", 32'(mdata_out != 8'h55), 32'd1);
         step("ovf.drain", 1'b0, 8'h00, 1'b1);
      end

      step("sim.p0", 1'b1, 8'hC1, 1'b0);
      step("sim.p1", 1'b1, 8'hC2, 1'b0);
      step("sim.both", 1'b1, 8'hC3, 1'b1);
      chk("sim.count", 32'(count), 32'd2);
      chk("sim.head", 32'(mdata_out), 32'hC2);
      step("sim.d0", 1'b0, 8'h00, 1'b1);
      step("sim.d1", 1'b0, 8'h00, 1'b1);

      for (int i = 0; i < 20; i++) begin
         step("stream", 1'b1, 8'(i + 1), 1'b1);
         chk("stream.count1", 32'(count), 32'd1);
         chk("stream.word", 32'(mdata_out), 32'(i + 1));
      end
      step("stream.tail", 1'b0, 8'h00, 1'b1);

      for (int i = 0; i < 300; i++) begin
         step("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));
      end
      for (int i = 0; i < 270; i++) step("sat", 1'b1, 8'($urandom), 1'b0);
      chk("sat.drop_cnt", 32'(drop_cnt), 32'd255);
      for (int i = 0; i < 200; i++) begin
         step("rand2", 1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 1)));
      end
      while (q.size() != 0) step("flush", 1'b0, 8'h00, 1'b1);

      for (int i = 0; i < 3; i++) step("mrst.fill", 1'b1, 8'(8'h30 + i), 1'b0);
      chk("mrst.pre_count", 32'(count), 32'd3);
      #2;
      rst = 1'b0;
      #1;
      chk("mrst.valid", 32'(valid), 32'd0);
      chk("mrst.count", 32'(count), 32'd0);
      chk("mrst.push_ready", 32'(push_ready), 32'd1);
      chk("mrst.drop_cnt", 32'(drop_cnt), 32'd0);
      q.delete();
      m_drop = 0;
      @(posedge clk);
      #1;
      check_state("mrst.hold");
      rst = 1'b1;
      step("mrst.push", 1'b1, 8'h7E, 1'b0);
      chk("mrst.first", 32'(mdata_out), 32'h7E);
      step("mrst.pop", 1'b0, 8'h00, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
